// File: rtl/dice_game_pkg.sv
// rtl/dice_game_pkg.sv - shared states, dice constants and come-out classification for dice_game_multi
package dice_game_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ROLL1 = 3'd1,
    ST_POINT = 3'd2,
    ST_ROLLN = 3'd3,
    ST_WIN   = 3'd4,
    ST_LOSE  = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    RES_WIN   = 2'd0,
    RES_LOSE  = 2'd1,
    RES_POINT = 2'd2,
    RES_BAD   = 2'd3
  } come_out_t;

  localparam logic [31:0] SUM_MIN   = 32'd2;
  localparam logic [31:0] SUM_MAX   = 32'd12;
  localparam logic [31:0] NATURAL_A = 32'd7;
  localparam logic [31:0] NATURAL_B = 32'd11;
  localparam logic [31:0] CRAPS_2   = 32'd2;
  localparam logic [31:0] CRAPS_3   = 32'd3;
  localparam logic [31:0] CRAPS_12  = 32'd12;
  localparam logic [31:0] SEVEN_OUT = 32'd7;

  function automatic logic sum_in_range(input logic [31:0] s);
    return (s >= SUM_MIN) && (s <= SUM_MAX);
  endfunction

  function automatic come_out_t come_out(input logic [31:0] s);
    if (!sum_in_range(s))
      return RES_BAD;
    if (s == NATURAL_A || s == NATURAL_B)
      return RES_WIN;
    if (s == CRAPS_2 || s == CRAPS_3 || s == CRAPS_12)
      return RES_LOSE;
    return RES_POINT;
  endfunction

endpackage

// File: rtl/dice_score_bank.sv
// rtl/dice_score_bank.sv - per-player saturating win counters, packed with player 0 in the LSBs
module dice_score_bank #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 8,
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic                           inc,
  input  logic [PW-1:0]                  index,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score
);

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_ctr
    logic [SCORE_W-1:0] ctr;

    always_ff @(posedge clk) begin
      if (rst || clear)
        ctr <= '0;
      else if (inc && (index == PW'(g)) && (ctr != '1))
        ctr <= ctr + SCORE_W'(1);
    end

    assign score[g*SCORE_W +: SCORE_W] = ctr;
  end

endmodule

// File: rtl/dice_game_multi.sv
// rtl/dice_game_multi.sv - multi-player craps controller: roll handshake, point rules, roll limit, turn rotation
module dice_game_multi
  import dice_game_pkg::*;
#(
  parameter int SUM_W       = 4,
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 8,
  parameter int MAX_ROLLS   = 15,
  localparam int PW = (NUM_PLAYERS > 1) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           rb,
  input  logic                           new_game,
  input  logic [SUM_W-1:0]               sum,
  input  logic                           sum_valid,
  output logic                           roll,
  output logic                           win,
  output logic                           lose,
  output logic                           timeout,
  output logic                           bad_sum,
  output logic [SUM_W-1:0]               point,
  output logic [PW-1:0]                  player,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score,
  output logic [2:0]                     state
);

  localparam int CW = (MAX_ROLLS > 0) ? $clog2(MAX_ROLLS + 1) : 1;

  state_t        st;
  logic          rb_q;
  logic [CW-1:0] roll_cnt;

  logic          rb_rise;
  logic [31:0]   sum_x;
  logic          sum_take;
  logic          in_range;
  logic          point_hit;
  logic          seven;
  logic [CW-1:0] cnt_next;
  logic          limit_hit;
  come_out_t     first_res;
  logic          score_inc;

  assign rb_rise   = rb & ~rb_q;
  assign sum_x     = 32'(sum);
  // roll is high exactly in ROLL1/ROLLN, so it doubles as the sample qualifier
  assign sum_take  = roll & sum_valid;
  assign in_range  = sum_in_range(sum_x);
  assign point_hit = (sum == point);
  assign seven     = (sum_x == SEVEN_OUT);
  assign cnt_next  = roll_cnt + CW'(1);
  assign limit_hit = (MAX_ROLLS != 0) && (cnt_next == CW'(MAX_ROLLS));
  assign first_res = come_out(sum_x);
  assign score_inc = !new_game && sum_take && in_range &&
                     (((st == ST_ROLL1) && (first_res == RES_WIN)) ||
                      ((st == ST_ROLLN) && point_hit));
  assign state     = st;

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= ST_IDLE;
      roll     <= 1'b0;
      win      <= 1'b0;
      lose     <= 1'b0;
      timeout  <= 1'b0;
      bad_sum  <= 1'b0;
      point    <= '0;
      player   <= '0;
      roll_cnt <= '0;
      rb_q     <= 1'b0;
    end else begin
      rb_q    <= rb;
      bad_sum <= 1'b0;
      if (new_game) begin
        st       <= ST_IDLE;
        roll     <= 1'b0;
        win      <= 1'b0;
        lose     <= 1'b0;
        timeout  <= 1'b0;
        point    <= '0;
        player   <= '0;
        roll_cnt <= '0;
      end else begin
        case (st)
          ST_IDLE: begin
            if (rb_rise) begin
              st   <= ST_ROLL1;
              roll <= 1'b1;
            end
          end
          ST_ROLL1: begin
            if (sum_take) begin
              case (first_res)
                RES_WIN: begin
                  st   <= ST_WIN;
                  roll <= 1'b0;
                  win  <= 1'b1;
                end
                RES_LOSE: begin
                  st   <= ST_LOSE;
                  roll <= 1'b0;
                  lose <= 1'b1;
                end
                RES_POINT: begin
                  st       <= ST_POINT;
                  roll     <= 1'b0;
                  point    <= sum;
                  roll_cnt <= '0;
                end
                default: bad_sum <= 1'b1;
              endcase
            end
          end
          ST_POINT: begin
            if (rb_rise) begin
              st   <= ST_ROLLN;
              roll <= 1'b1;
            end
          end
          ST_ROLLN: begin
            if (sum_take) begin
              if (!in_range) begin
                bad_sum <= 1'b1;
              end else if (point_hit) begin
                st   <= ST_WIN;
                roll <= 1'b0;
                win  <= 1'b1;
              end else if (seven) begin
                st   <= ST_LOSE;
                roll <= 1'b0;
                lose <= 1'b1;
              end else begin
                roll     <= 1'b0;
                roll_cnt <= cnt_next;
                if (limit_hit) begin
                  st      <= ST_LOSE;
                  lose    <= 1'b1;
                  timeout <= 1'b1;
                end else begin
                  st <= ST_POINT;
                end
              end
            end
          end
          ST_WIN, ST_LOSE: begin
            if (rb_rise) begin
              st      <= ST_ROLL1;
              roll    <= 1'b1;
              win     <= 1'b0;
              lose    <= 1'b0;
              timeout <= 1'b0;
              point   <= '0;
              player  <= (player == PW'(NUM_PLAYERS - 1)) ? '0 : player + PW'(1);
            end
          end
          default: begin
            st   <= ST_IDLE;
            roll <= 1'b0;
            win  <= 1'b0;
            lose <= 1'b0;
          end
        endcase
      end
    end
  end

  dice_score_bank #(
    .NUM_PLAYERS(NUM_PLAYERS),
    .SCORE_W    (SCORE_W)
  ) u_score_bank (
    .clk  (clk),
    .rst  (rst),
    .clear(new_game),
    .inc  (score_inc),
    .index(player),
    .score(score)
  );

endmodule
